// File: rtl/secure_reg_pkg.sv
// secure_reg_pkg: FSM states, response codes and privileged thread id
package secure_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DENIED  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam int unsigned PRIV_TID = 0;

endpackage

// File: rtl/secure_cmd_fifo.sv
// secure_cmd_fifo: synchronous command queue; push+pop succeed together even when full or empty
module secure_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = wr_ptr == rd_ptr;
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && (!empty || push);
   assign do_push  = push && (!full || pop);
   assign pop_data = empty ? push_data : mem[rd_ptr[AW-1:0]];

   // pointer bookkeeping; extra msb distinguishes full from empty
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/secure_reg_initiator.sv
// secure_reg_initiator: queues thread commands and issues them to a secure register, one at a time
module secure_reg_initiator
   import secure_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TID_WIDTH  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [TID_WIDTH-1:0]  cmd_tid,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  reg_req,
   output logic                  reg_wr_en,
   output logic [TID_WIDTH-1:0]  reg_thread_id,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic                  reg_ack,
   input  logic                  reg_grant,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_err
);

   localparam int CW = $clog2(TIMEOUT + 2);
   localparam int FW = 1 + TID_WIDTH + DATA_WIDTH;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic                  wk_write;
   logic [TID_WIDTH-1:0]  wk_tid;
   logic [DATA_WIDTH-1:0] wk_wdata;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [1:0]            rsp_code;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [FW-1:0]         head;
   logic                  head_write;
   logic [TID_WIDTH-1:0]  head_tid;
   logic [DATA_WIDTH-1:0] head_wdata;

   assign cmd_ready  = !fifo_full;
   assign fifo_push  = cmd_valid && cmd_ready;
   assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
   assign head_write = head[FW-1];
   assign head_tid   = head[DATA_WIDTH +: TID_WIDTH];
   assign head_wdata = head[DATA_WIDTH-1:0];

   secure_cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({cmd_write, cmd_tid, cmd_wdata}),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // access sequencer: only the privileged thread ever reaches the register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         wk_write <= 1'b0;
         wk_tid   <= '0;
         wk_wdata <= '0;
         rsp_data <= '0;
         rsp_code <= ERR_OK;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  wk_write <= head_write;
                  wk_tid   <= head_tid;
                  wk_wdata <= head_wdata;
                  cnt      <= '0;
                  rsp_data <= '0;
                  if (head_tid == TID_WIDTH'(PRIV_TID)) begin
                     state    <= ST_ISSUE;
                     rsp_code <= ERR_OK;
                  end else begin
                     state    <= ST_RESP;
                     rsp_code <= ERR_DENIED;
                  end
               end
            end
            ST_ISSUE: begin
               cnt <= cnt + 1'b1;
               if (reg_ack) begin
                  state    <= ST_RESP;
                  rsp_code <= reg_grant ? ERR_OK : ERR_DENIED;
                  rsp_data <= (reg_grant && !wk_write) ? reg_rdata : '0;
               end else if (cnt == CW'(TIMEOUT)) begin
                  state    <= ST_RESP;
                  rsp_code <= ERR_TIMEOUT;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign reg_req       = state == ST_ISSUE;
   assign reg_wr_en     = reg_req && wk_write;
   assign reg_thread_id = reg_req ? wk_tid : '0;
   assign reg_wdata     = reg_req ? wk_wdata : '0;
   assign rsp_valid     = state == ST_RESP;
   assign rsp_rdata     = rsp_valid ? rsp_data : '0;
   assign rsp_err       = rsp_valid ? rsp_code : ERR_OK;

endmodule

// File: tb/tb_secure_reg_initiator.sv
// tb_secure_reg_initiator: directed and randomized checks against a transaction-level model
module tb_secure_reg_initiator;

   localparam int DW = 32;
   localparam int TW = 4;
   localparam int DEPTH = 4;
   localparam int TO = 15;

   typedef struct {
      bit          wr;
      logic [TW-1:0] tid;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      int          delay;
      bit          grant;
      logic [DW-1:0] data;
      bit          wr;
      logic [TW-1:0] tid;
      logic [DW-1:0] wdata;
      int          len;
      bit          stable;
   } acc_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [TW-1:0] cmd_tid;
   logic [DW-1:0] cmd_wdata;
   logic          reg_req;
   logic          reg_wr_en;
   logic [TW-1:0] reg_thread_id;
   logic [DW-1:0] reg_wdata;
   logic          reg_ack;
   logic          reg_grant;
   logic [DW-1:0] reg_rdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_err;

   int checks = 0;
   int failures = 0;

   cmd_t cmd_q[$];
   acc_t acc_q[$];

   bit            rand_resp = 1'b0;
   int            fix_delay = 0;
   bit            fix_grant = 1'b1;
   logic [DW-1:0] fix_data = '0;

   always #5 clk = ~clk;

   secure_reg_initiator #(
      .DATA_WIDTH (DW),
      .TID_WIDTH  (TW),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_tid       (cmd_tid),
      .cmd_wdata     (cmd_wdata),
      .reg_req       (reg_req),
      .reg_wr_en     (reg_wr_en),
      .reg_thread_id (reg_thread_id),
      .reg_wdata     (reg_wdata),
      .reg_ack       (reg_ack),
      .reg_grant     (reg_grant),
      .reg_rdata     (reg_rdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err)
   );

   // register-side responder: decides ack delay/grant/data per access and logs what it saw
   initial begin
      int   k;
      int   r;
      acc_t cur;
      k = 0;
      reg_ack = 1'b0;
      reg_grant = 1'b0;
      reg_rdata = '0;
      forever begin
         @(negedge clk);
         if (reg_req === 1'b1) begin
            if (k == 0) begin
               r = $urandom_range(0, 7);
               cur.delay = rand_resp ? (r == 0 ? TO : r == 1 ? TO + 1 : int'($urandom_range(0, 4))) : fix_delay;
               cur.grant = rand_resp ? 1'($urandom_range(0, 1)) : fix_grant;
               cur.data = rand_resp ? DW'($urandom) : fix_data;
               cur.wr = reg_wr_en;
               cur.tid = reg_thread_id;
               cur.wdata = reg_wdata;
               cur.len = 0;
               cur.stable = 1'b1;
               acc_q.push_back(cur);
            end
            cur.len++;
            if ({reg_wr_en, reg_thread_id, reg_wdata} !== {cur.wr, cur.tid, cur.wdata}) cur.stable = 1'b0;
            if (acc_q.size() > 0) acc_q[acc_q.size() - 1] = cur;
            reg_ack = (k == cur.delay);
            reg_grant = reg_ack ? cur.grant : 1'b0;
            reg_rdata = reg_ack ? cur.data : DW'($urandom);
            k++;
         end else begin
            k = 0;
            reg_ack = 1'b0;
            reg_grant = 1'b0;
            reg_rdata = '0;
         end
      end
   end

   // spec-level outcome of one command given what the register did
   function automatic void model(input cmd_t c, input acc_t a, output logic [1:0] e, output logic [DW-1:0] d, output int len);
      len = 0;
      if (c.tid != 0) begin
         e = 2'b01;
         d = '0;
      end else if (a.delay <= TO) begin
         e = a.grant ? 2'b00 : 2'b01;
         d = (a.grant && !c.wr) ? a.data : '0;
         len = a.delay + 1;
      end else begin
         e = 2'b10;
         d = '0;
         len = TO + 1;
      end
   endfunction

   task automatic push_cmd(input bit wr, input logic [TW-1:0] tid, input logic [DW-1:0] wdata, output bit ok);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_tid = tid;
      cmd_wdata = wdata;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = cmd_ready === 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit seen, output logic [1:0] e, output logic [DW-1:0] d);
      int n;
      rsp_ready = 1'b1;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      seen = rsp_valid === 1'b1;
      e = rsp_err;
      d = rsp_rdata;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      checks++;
      if ({reg_req, reg_wr_en, reg_thread_id, reg_wdata} !== '0) begin failures++; $display("FAIL reset_reg_outputs: got %0h expected 0", {reg_req, reg_wr_en, reg_thread_id, reg_wdata}); end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin failures++; $display("FAIL reset_rsp_outputs: got %0h expected 0", {rsp_valid, rsp_err, rsp_rdata}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (reg_req !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_idle: got req=%b valid=%b expected 0 0", reg_req, rsp_valid); end
   endtask

   task automatic test_read_grant();
      bit ok, seen;
      logic [1:0] e;
      logic [DW-1:0] d;
      acc_q.delete();
      rand_resp = 1'b0; fix_delay = 3; fix_grant = 1'b1; fix_data = 32'hDEADBEEF;
      push_cmd(1'b0, '0, '0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL read_push: got not accepted expected accepted"); end
      checks++;
      if (reg_req !== 1'b0) begin failures++; $display("FAIL read_latency_early: got reg_req=%b expected 0", reg_req); end
      @(negedge clk);
      checks++;
      if (reg_req !== 1'b1 || reg_wr_en !== 1'b0 || reg_thread_id !== '0) begin failures++; $display("FAIL read_latency_req: got req=%b wr=%b tid=%0h expected 1 0 0", reg_req, reg_wr_en, reg_thread_id); end
      wait_rsp(seen, e, d);
      checks++;
      if (!seen || e !== 2'b00 || d !== 32'hDEADBEEF) begin failures++; $display("FAIL read_grant_rsp: got seen=%b err=%b data=%h expected 1 00 deadbeef", seen, e, d); end
      checks++;
      if (acc_q.size() != 1 || acc_q[0].len != 4) begin failures++; $display("FAIL read_grant_req_len: got n=%0d expected 1 access of 4 cycles", acc_q.size()); end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin failures++; $display("FAIL read_rsp_release: got valid=%b data=%h expected 0 0", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_denied_tid();
      bit ok, seen;
      logic [1:0] e;
      logic [DW-1:0] d;
      acc_q.delete();
      push_cmd(1'b1, 4'd3, 32'h1234, ok);
      wait_rsp(seen, e, d);
      checks++;
      if (!ok || !seen || e !== 2'b01 || d !== '0) begin failures++; $display("FAIL denied_tid_rsp: got ok=%b seen=%b err=%b data=%h expected 1 1 01 0", ok, seen, e, d); end
      checks++;
      if (acc_q.size() != 0) begin failures++; $display("FAIL denied_tid_no_req: got %0d accesses expected 0", acc_q.size()); end
      @(negedge clk);
   endtask

   task automatic test_grant_denied();
      bit ok, seen;
      logic [1:0] e;
      logic [DW-1:0] d;
      acc_q.delete();
      rand_resp = 1'b0; fix_delay = 1; fix_grant = 1'b0; fix_data = 32'hFFFFFFFF;
      push_cmd(1'b0, '0, '0, ok);
      wait_rsp(seen, e, d);
      checks++;
      if (!ok || !seen || e !== 2'b01 || d !== '0) begin failures++; $display("FAIL grant_denied_rsp: got seen=%b err=%b data=%h expected 1 01 0", seen, e, d); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok, seen;
      logic [1:0] e;
      logic [DW-1:0] d;
      acc_q.delete();
      rand_resp = 1'b0; fix_delay = 1000; fix_grant = 1'b1; fix_data = 32'hA5A5A5A5;
      push_cmd(1'b1, '0, 32'hCAFE, ok);
      wait_rsp(seen, e, d);
      checks++;
      if (!ok || !seen || e !== 2'b10 || d !== '0) begin failures++; $display("FAIL timeout_rsp: got seen=%b err=%b data=%h expected 1 10 0", seen, e, d); end
      checks++;
      if (acc_q.size() != 1 || acc_q[0].len != TO + 1 || !acc_q[0].stable || acc_q[0].wdata !== 32'hCAFE) begin failures++; $display("FAIL timeout_req_len: got n=%0d len=%0d expected 1 access of %0d stable cycles", acc_q.size(), acc_q.size() ? acc_q[0].len : -1, TO + 1); end
      @(negedge clk);
      acc_q.delete();
      fix_delay = TO;
      push_cmd(1'b0, '0, '0, ok);
      wait_rsp(seen, e, d);
      checks++;
      if (!seen || e !== 2'b00 || d !== 32'hA5A5A5A5) begin failures++; $display("FAIL ack_at_timeout: got seen=%b err=%b data=%h expected 1 00 a5a5a5a5", seen, e, d); end
      checks++;
      if (acc_q.size() != 1 || acc_q[0].len != TO + 1) begin failures++; $display("FAIL ack_at_timeout_len: got n=%0d expected 1 access of %0d cycles", acc_q.size(), TO + 1); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      cmd_t c[5];
      acc_t a;
      logic [1:0] e;
      logic [DW-1:0] d;
      int len, n;
      acc_q.delete();
      rand_resp = 1'b1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c[i].wr = 1'(i % 2);
         c[i].tid = (i == 1 || i == 4) ? TW'(i + 5) : '0;
         c[i].wdata = DW'($urandom);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_write = c[i].wr;
         cmd_tid = c[i].tid;
         cmd_wdata = c[i].wdata;
         checks++;
         if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, cmd_ready); end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: got cmd_ready=%b expected 0", cmd_ready); end
      repeat (20) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall: got ready=%b valid=%b expected 0 1", cmd_ready, rsp_valid); end
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n = 0;
         while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         a = '{delay: 0, grant: 0, data: '0, wr: 0, tid: '0, wdata: '0, len: 0, stable: 0};
         if (c[i].tid == 0 && acc_q.size() > 0) a = acc_q.pop_front();
         model(c[i], a, e, d, len);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== e || rsp_rdata !== d) begin failures++; $display("FAIL b2b_rsp_%0d: got valid=%b err=%b data=%h expected 1 %b %h", i, rsp_valid, rsp_err, rsp_rdata, e, d); end
         @(negedge clk);
      end
      checks++;
      if (acc_q.size() != 0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %0d extra accesses valid=%b expected 0 0", acc_q.size(), rsp_valid); end
   endtask

   task automatic test_reset_in_issue();
      bit ok1, ok2;
      int seen;
      acc_q.delete();
      rand_resp = 1'b0; fix_delay = 1000;
      rsp_ready = 1'b1;
      push_cmd(1'b0, '0, '0, ok1);
      push_cmd(1'b1, '0, 32'h55, ok2);
      checks++;
      if (!ok1 || !ok2 || reg_req !== 1'b1) begin failures++; $display("FAIL rst_issue_setup: got ok=%b%b req=%b expected 11 1", ok1, ok2, reg_req); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (reg_req !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_issue_next: got req=%b valid=%b ready=%b expected 0 0 1", reg_req, rsp_valid, cmd_ready); end
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (reg_req !== 1'b0 || rsp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL rst_issue_flushed: got %0d active cycles expected 0", seen); end
   endtask

   task automatic test_random();
      acc_q.delete();
      cmd_q.delete();
      rand_resp = 1'b1;
      fork
         begin
            cmd_t c;
            int sent;
            bit hold;
            sent = 0;
            hold = 1'b0;
            for (int cyc = 0; cyc < 6000 && sent < 40; cyc++) begin
               @(negedge clk);
               if (!hold) begin
                  if ($urandom_range(0, 2) != 0) begin
                     c.wr = 1'($urandom_range(0, 1));
                     c.tid = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(1, 15)) : '0;
                     c.wdata = DW'($urandom);
                     cmd_valid = 1'b1;
                     cmd_write = c.wr;
                     cmd_tid = c.tid;
                     cmd_wdata = c.wdata;
                     hold = 1'b1;
                  end else begin
                     cmd_valid = 1'b0;
                  end
               end
               if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                  cmd_q.push_back(c);
                  sent++;
                  hold = 1'b0;
               end
            end
            @(negedge clk);
            cmd_valid = 1'b0;
         end
         begin
            cmd_t c;
            acc_t a;
            logic [1:0] e;
            logic [DW-1:0] d;
            int len, got;
            got = 0;
            for (int cyc = 0; cyc < 8000 && got < 40; cyc++) begin
               @(negedge clk);
               rsp_ready = 1'($urandom_range(0, 1));
               if (rsp_valid === 1'b1 && rsp_ready) begin
                  got++;
                  checks++;
                  if (cmd_q.size() == 0) begin
                     failures++;
                     $display("FAIL rand_unexpected_rsp: got err=%b with no command pending", rsp_err);
                  end else begin
                     c = cmd_q.pop_front();
                     a = '{delay: 0, grant: 0, data: '0, wr: 0, tid: '0, wdata: '0, len: 0, stable: 1};
                     if (c.tid == 0) begin
                        checks++;
                        if (acc_q.size() == 0) begin
                           failures++;
                           $display("FAIL rand_no_access: got no reg_req expected one for tid 0");
                           a.delay = 1000;
                        end else begin
                           a = acc_q.pop_front();
                           if (!a.stable || a.wr !== c.wr || a.tid !== c.tid || a.wdata !== c.wdata) begin failures++; $display("FAIL rand_reg_fields: got wr=%b tid=%0h wdata=%h stable=%b expected %b %0h %h 1", a.wr, a.tid, a.wdata, a.stable, c.wr, c.tid, c.wdata); end
                        end
                     end
                     model(c, a, e, d, len);
                     if (rsp_err !== e || rsp_rdata !== d || (c.tid == 0 && a.len != len)) begin failures++; $display("FAIL rand_rsp_%0d: got err=%b data=%h len=%0d expected %b %h %0d", got, rsp_err, rsp_rdata, a.len, e, d, len); end
                  end
                  checks++;
                  if ({reg_req, reg_wr_en, reg_thread_id, reg_wdata} !== '0) begin failures++; $display("FAIL rand_reg_idle: got %h expected 0", {reg_req, reg_wr_en, reg_thread_id, reg_wdata}); end
               end
            end
            checks++;
            if (got != 40) begin failures++; $display("FAIL rand_count: got %0d responses expected 40", got); end
         end
      join
      @(negedge clk);
      checks++;
      if (acc_q.size() != 0 || cmd_q.size() != 0) begin failures++; $display("FAIL rand_leftover: got acc=%0d cmd=%0d expected 0 0", acc_q.size(), cmd_q.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_tid = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_read_grant();
      test_denied_tid();
      test_grant_denied();
      test_timeout();
      test_back_to_back();
      test_reset_in_issue();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/secure_reg_initiator.md
SECURE_REG_INITIATOR -- requirements
Module: secure_reg_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the data path width.
REQ-002 Parameter TID_WIDTH, default 4, sets the thread-id width.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, >=2), sets the command queue depth.
REQ-004 Parameter TIMEOUT, default 15, sets the maximum ISSUE cycles waiting for reg_ack.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command queue can accept.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_tid  input  TID_WIDTH  requesting thread id.
REQ-011 cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 reg_req  output  1  access request to the secure register.
REQ-013 reg_wr_en  output  1  write strobe qualifier for reg_req.
REQ-014 reg_thread_id  output  TID_WIDTH  thread id presented with reg_req.
REQ-015 reg_wdata  output  DATA_WIDTH  data presented with reg_req.
REQ-016 reg_ack  input  1  register completed the access.
REQ-017 reg_grant  input  1  sampled with reg_ack; 1 = access permitted.
REQ-018 reg_rdata  input  DATA_WIDTH  read data, valid with reg_ack.
REQ-019 rsp_valid  output  1  response available.
REQ-020 rsp_ready  input  1  response consumed.
REQ-021 rsp_rdata  output  DATA_WIDTH  read data; zero for writes and errors.
REQ-022 rsp_err  output  2  00 OK, 01 DENIED, 10 TIMEOUT.

Function
REQ-023 Command is pushed on cycles with cmd_valid && cmd_ready; cmd_ready = !fifo_full.
REQ-024 Simultaneous push and pop on a full or empty FIFO both succeed; occupancy unchanged, order preserved.
REQ-025 FSM states: IDLE, ISSUE, RESP.
REQ-026 IDLE with FIFO non-empty: pop head into working registers; next state ISSUE if head tid == 0, else RESP with rsp_err=DENIED (no reg_req ever asserted for tid != 0).
REQ-027 ISSUE: reg_req=1, reg_wr_en/reg_thread_id/reg_wdata held stable from working registers; timeout counter increments each cycle.
REQ-028 ISSUE with reg_ack: next state RESP; rsp_err = reg_grant ? OK : DENIED; rsp_rdata = reg_rdata only for granted reads, else zero.
REQ-029 ISSUE with counter == TIMEOUT and no reg_ack: drop reg_req, next state RESP, rsp_err=TIMEOUT; ack arriving in that same cycle takes priority over timeout.
REQ-030 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready next state IDLE, counter cleared.
REQ-031 Outputs reg_* are zero outside ISSUE; rsp_* are zero outside RESP.
REQ-032 Minimum latency push-to-reg_req is 2 cycles (push N, pop in IDLE N+1, reg_req N+2); one command in flight at a time.

Reset
REQ-033 rst_n low at a clock edge empties the FIFO, forces IDLE, clears counter and working registers; all outputs 0 except cmd_ready=1 in the following cycle.
REQ-034 Reset asserted in ISSUE or RESP abandons the access: reg_req and rsp_valid are 0 the cycle after, no response is produced.

Structure
REQ-035 Package secure_reg_pkg holds the FSM state enum, the rsp_err encoding constants and the privileged thread-id constant (0).
REQ-036 The command queue is the sub-module secure_cmd_fifo (synchronous FIFO, push/pop/full/empty).

Verification
REQ-037 Read tid=0, reg_ack+grant after 3 cycles with rdata=0xDEADBEEF -> rsp_valid, rsp_err=00, rsp_rdata=0xDEADBEEF.
REQ-038 Write tid=3 wdata=0x1234 -> reg_req never asserted, rsp_err=01, rsp_rdata=0.
REQ-039 Read tid=0, reg_ack with reg_grant=0 -> rsp_err=01, rsp_rdata=0 despite reg_rdata=0xFFFFFFFF.
REQ-040 tid=0 access, reg_ack never -> reg_req high exactly TIMEOUT+1 cycles, then rsp_err=10.
REQ-041 Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready low after 4th queued (+1 in flight), responses in push order once released.
REQ-042 rst_n low during ISSUE -> next cycle reg_req=0, FIFO empty, cmd_ready=1, no rsp_valid.
